// File: rtl/fadd_norm_round.sv
// Post-addition normalize-and-round stage of the fp32 add/sub path.
// Two-stage valid/ready pipeline: leading-zero count, then shift/round/pack.
module fadd_norm_round #(
    parameter bit RND_EN = 1'b1,
    parameter bit FTZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [31:0] in_mant,
    input  logic        in_sticky,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags
);

    // Leading-zero count of a 32-bit word; 32 when the word is zero.
    function automatic logic [5:0] lza_32(input logic [31:0] v);
        lza_32 = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) lza_32 = 6'(31 - i);
        end
    endfunction

    logic        s1_valid;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [31:0] s1_mant;
    logic        s1_sticky;
    logic [5:0]  s1_count;

    logic        adv2;
    logic        in_fire;

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv2;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= 8'd0;
            s1_mant   <= 32'd0;
            s1_sticky <= 1'b0;
            s1_count  <= 6'd0;
        end else if (in_fire) begin
            s1_valid  <= 1'b1;
            s1_sign   <= in_sign;
            s1_exp    <= in_exp;
            s1_mant   <= in_mant;
            s1_sticky <= in_sticky;
            s1_count  <= lza_32(in_mant);
        end else if (adv2) begin
            s1_valid  <= 1'b0;
        end
    end

    logic [31:0] sh;
    logic [9:0]  e_pre;
    logic [9:0]  e_fin;
    logic [22:0] frac;
    logic        g_bit;
    logic        s_bit;
    logic        inc;
    logic [23:0] frac_r;
    logic        inexact;
    logic        is_zero;
    logic        uf;
    logic        ov;
    logic [31:0] res;
    logic [3:0]  flg;

    // Exponent is kept 10-bit two's complement so underflow shows as <= 0.
    always_comb begin
        sh      = s1_mant << s1_count;
        e_pre   = {2'b00, s1_exp} + 10'd1 - {4'b0000, s1_count};
        frac    = sh[30:8];
        g_bit   = sh[7];
        s_bit   = (|sh[6:0]) || s1_sticky;
        inexact = g_bit || s_bit;
        inc     = RND_EN && g_bit && (s_bit || frac[0]);
        frac_r  = {1'b0, frac} + {23'd0, inc};
        e_fin   = e_pre + {9'd0, frac_r[23]};
        is_zero = (s1_mant == 32'd0);
        uf      = FTZ && ($signed(e_fin) <= 10'sd0);
        ov      = ($signed(e_fin) >= 10'sd255);
        res     = {s1_sign, e_fin[7:0], frac_r[22:0]};
        flg     = {1'b0, 1'b0, inexact, 1'b0};
        if (is_zero) begin
            res = 32'd0;
            flg = 4'b0001;
        end else if (uf) begin
            res = {s1_sign, 31'd0};
            flg = 4'b0111;
        end else if (ov) begin
            res = {s1_sign, 8'hFF, 23'd0};
            flg = 4'b1010;
        end
    end

    // Output register only moves when downstream can take it, holding results stable under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= 32'd0;
            out_flags  <= 4'd0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= res;
                out_flags  <= flg;
            end
        end
    end

endmodule

// File: tb/tb_fadd_norm_round.sv
// Bench for fadd_norm_round: a round-to-nearest and a truncating instance share stimulus,
// results are checked against a queue of hand-derived expectations.
module tb_fadd_norm_round;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [31:0] in_mant;
    logic        in_sticky;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic        t_in_ready;
    logic        t_out_valid;
    logic [31:0] t_out_result;
    logic [3:0]  t_out_flags;

    fadd_norm_round #(.RND_EN(1'b1), .FTZ(1'b1)) dut_rne (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    fadd_norm_round #(.RND_EN(1'b0), .FTZ(1'b1)) dut_trn (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(t_in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_sticky(in_sticky),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .out_result(t_out_result), .out_flags(t_out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        sticky;
        logic [31:0] r_rne;
        logic [3:0]  f_rne;
        logic [31:0] r_trn;
        logic [3:0]  f_trn;
    } vec_t;

    vec_t vecs [16];
    vec_t sb [$];

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int cur_idx = 0;
    int bp_mode = 0;
    int bp_cnt = 0;
    int lat_state = 0;
    int lat_cycle = 0;
    logic accepted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] m, input logic [7:0] e, input logic s,
                           input logic st, input logic [31:0] rr, input logic [3:0] fr,
                           input logic [31:0] rt, input logic [3:0] ft);
        vecs[i] = '{m, e, s, st, rr, fr, rt, ft};
    endtask

    function automatic logic pick_ready();
        if (bp_mode == 0) return 1'b1;
        if (bp_mode == 2) return 1'b0;
        bp_cnt++;
        if (bp_cnt >= 3 && bp_cnt <= 7) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: settle, compare visible outputs against the scoreboard, then cross the edge.
    task automatic step();
        logic take_in;
        logic take_out;
        #2;
        check("in_ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2) || out_ready});
        check("trn_valid", {31'd0, t_out_valid}, {31'd0, out_valid});
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                check("rne_result", out_result, sb[0].r_rne);
                check("rne_flags", {28'd0, out_flags}, {28'd0, sb[0].f_rne});
                check("trn_result", t_out_result, sb[0].r_trn);
                check("trn_flags", {28'd0, t_out_flags}, {28'd0, sb[0].f_trn});
            end
            if (lat_state == 2) begin
                check("latency", 32'(cycle - lat_cycle), 32'd2);
                lat_state = 0;
            end
        end
        take_out = out_valid && out_ready;
        take_in  = in_valid && in_ready;
        if (take_out && sb.size() > 0) void'(sb.pop_front());
        if (take_in) begin
            sb.push_back(vecs[cur_idx]);
            if (lat_state == 1) begin
                lat_cycle = cycle;
                lat_state = 2;
            end
        end
        accepted = take_in;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic apply_stimulus(input int idx, output int tries);
        cur_idx   = idx;
        in_mant   = vecs[idx].mant;
        in_exp    = vecs[idx].exp;
        in_sign   = vecs[idx].sign;
        in_sticky = vecs[idx].sticky;
        in_valid  = 1'b1;
        tries     = 0;
        accepted  = 1'b0;
        for (int n = 0; n < 40 && !accepted; n++) begin
            out_ready = pick_ready();
            step();
            tries++;
        end
        if (!accepted) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_output();
        in_valid = 1'b0;
        for (int n = 0; n < 80 && sb.size() > 0; n++) begin
            out_ready = pick_ready();
            step();
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int tries;
        set_vec(0,  32'h40000000, 8'd127, 1'b0, 1'b0, 32'h3F800000, 4'h0, 32'h3F800000, 4'h0);
        set_vec(1,  32'h80000000, 8'd127, 1'b0, 1'b0, 32'h40000000, 4'h0, 32'h40000000, 4'h0);
        set_vec(2,  32'h80000000, 8'd127, 1'b1, 1'b0, 32'hC0000000, 4'h0, 32'hC0000000, 4'h0);
        set_vec(3,  32'h7FFFFFC0, 8'd127, 1'b0, 1'b0, 32'h40000000, 4'h2, 32'h3FFFFFFF, 4'h2);
        set_vec(4,  32'h00000000, 8'd99,  1'b1, 1'b1, 32'h00000000, 4'h1, 32'h00000000, 4'h1);
        set_vec(5,  32'h80000000, 8'd254, 1'b0, 1'b0, 32'h7F800000, 4'hA, 32'h7F800000, 4'hA);
        set_vec(6,  32'h00000001, 8'd10,  1'b1, 1'b0, 32'h80000000, 4'h7, 32'h80000000, 4'h7);
        set_vec(7,  32'h80000080, 8'd127, 1'b0, 1'b0, 32'h40000000, 4'h2, 32'h40000000, 4'h2);
        set_vec(8,  32'h80000080, 8'd127, 1'b0, 1'b1, 32'h40000001, 4'h2, 32'h40000000, 4'h2);
        set_vec(9,  32'hFFFFFFFF, 8'd253, 1'b0, 1'b0, 32'h7F800000, 4'hA, 32'h7F7FFFFF, 4'h2);
        set_vec(10, 32'h40000000, 8'd0,   1'b0, 1'b0, 32'h00000000, 4'h7, 32'h00000000, 4'h7);
        set_vec(11, 32'h40000000, 8'd1,   1'b0, 1'b0, 32'h00800000, 4'h0, 32'h00800000, 4'h0);
        set_vec(12, 32'h40000000, 8'd254, 1'b0, 1'b0, 32'h7F000000, 4'h0, 32'h7F000000, 4'h0);
        set_vec(13, 32'h40000000, 8'd127, 1'b0, 1'b1, 32'h3F800000, 4'h2, 32'h3F800000, 4'h2);
        set_vec(14, 32'h00000100, 8'd150, 1'b0, 1'b0, 32'h40000000, 4'h0, 32'h40000000, 4'h0);
        set_vec(15, 32'h00000003, 8'd140, 1'b1, 1'b0, 32'hB7C00000, 4'h0, 32'hB7C00000, 4'h0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_sign = 1'b0; in_exp = 8'd0; in_mant = 32'd0; in_sticky = 1'b0;
        #12;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_result", out_result, 32'd0);
        check("reset_out_flags", {28'd0, out_flags}, 32'd0);
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Single beat to measure latency.
        bp_mode = 0; lat_state = 1;
        apply_stimulus(0, tries);
        check_output();
        check("latency_seen", 32'(lat_state), 32'd0);

        // Full table back to back: every beat must be taken on its first cycle.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(i, tries);
            check("throughput", 32'(tries), 32'd1);
        end
        check_output();

        // Random back-pressure with a five-cycle stall window.
        bp_mode = 1; bp_cnt = 0;
        for (int i = 0; i < 8; i++) apply_stimulus(i + 3, tries);
        check_output();

        // Fill both stages, then reset asynchronously between edges.
        bp_mode = 2;
        apply_stimulus(1, tries);
        apply_stimulus(5, tries);
        check("both_full", 32'(sb.size()), 32'd2);
        in_valid = 1'b0;
        #2; rst_n = 1'b0; #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_result", out_result, 32'd0);
        check("async_rst_flags", {28'd0, out_flags}, 32'd0);
        check("async_rst_trn_valid", {31'd0, t_out_valid}, 32'd0);
        sb.delete();
        @(posedge clk); @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        bp_mode = 0; out_ready = 1'b1;
        for (int n = 0; n < 6; n++) step();
        check("no_stale_beat", {31'd0, out_valid}, 32'd0);

        apply_stimulus(15, tries);
        check_output();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fadd_norm_round.md
Name: fadd_norm_round

Overview:
- Post-addition normalize-and-round stage of the fp32 add/sub path in the vfpu.
- Consumes the unnormalized 32-bit magnitude from the alignment adder and counts its leading zeros with the existing lza_32 (6-bit count, 32 for all-zero input).
- Left-shifts, adjusts the exponent, rounds, and packs an IEEE-754 single result.
- 2-stage pipeline with valid/ready handshake on both sides.

Parameters:
- RND_EN, 1, 1 = round-to-nearest-even, 0 = truncate (round-toward-zero).
- FTZ, 1, 1 = flush subnormal results to signed zero (only supported value; 0 reserved).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept input.
- in_sign  input  1  result sign.
- in_exp  input  8  biased exponent; bit 30 of in_mant carries weight 2^(in_exp-127).
- in_mant  input  32  unsigned magnitude; bit 31 is the carry position.
- in_sticky  input  1  OR of bits shifted out during alignment.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  32  packed fp32 {sign, exp[7:0], frac[22:0]}.
- out_flags  output  4  {overflow, underflow, inexact, zero}.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid = 0, out_valid = 0, out_result = 0, out_flags = 0, in_ready = 1 one cycle after release. Reset mid-operation discards all in-flight beats.
- Handshake: a transfer occurs when valid and ready are both high at a rising edge.
- adv2 = !out_valid | out_ready. in_ready = !s1_valid | adv2, combinational, with no dependence on in_valid.
- Stage 1 (on input transfer): register sign, exp, mant, sticky, and count = lza_32(in_mant). s1_valid is set on transfer; it is cleared when stage 2 takes the beat and no new input arrives.
- Stage 2 (on adv2 & s1_valid): compute result, set out_valid. If adv2 and !s1_valid, clear out_valid.
- Stage 2 holds out_result and out_flags stable while out_valid & !out_ready.
- Latency: 2 cycles with no back-pressure; full throughput of 1 beat per cycle.
- Normalize: sh = mant << count, so sh[31] = 1 unless mant = 0. e = in_exp + 1 - count, as 10-bit signed (range -31..256).
- Round:
  - frac = sh[30:8], g = sh[7], s = |sh[6:0] | sticky.
  - inexact = g | s.
  - RNE increments when g & (s | frac[0]). Truncate never increments.
  - If the increment carries out of frac: frac = 0, e = e + 1.
- Zero: mant = 0 gives result 0x00000000 (sign forced 0), flags = 0001. in_sticky is ignored in this case.
- Underflow: e <= 0 gives {sign, 31'b0}, flags underflow = 1, inexact = 1, zero = 1.
- Overflow: e >= 255 (after rounding carry) gives {sign, 8'hFF, 23'b0}, flags overflow = 1, inexact = 1.
- Otherwise: {sign, e[7:0], frac}, with the inexact flag as computed.
- Simultaneous events: input accept and output drain in the same cycle with both stages full must proceed without a bubble or loss.
- in_ready never depends on out_valid when s1 is empty.

Test Plan:
- mant = 0x40000000, exp = 127, sign = 0 -> count 1, out_result = 0x3F800000, flags = 0000, out_valid exactly 2 cycles after accept.
- mant = 0x80000000, exp = 127 -> 0x40000000. Same input with sign = 1 -> 0xC0000000.
- Rounding carry, RND_EN = 1: mant = 0x7FFFFFC0, exp = 127 -> tie with frac lsb 1, rounds up with carry, 0x40000000, flags = 0010. Same with RND_EN = 0 -> 0x3FFFFFFF, flags = 0010.
- Edge values:
  - mant = 0 -> 0x00000000, flags = 0001.
  - mant = 0x80000000, exp = 254 -> 0x7F800000, flags = 1010.
  - mant = 0x00000001, exp = 10, sign = 1 -> 0x80000000, flags = 0111.
- Back-pressure: 8 back-to-back beats with out_ready toggling randomly, including 5 consecutive low cycles -> in_ready drops after 2 beats are buffered; all 8 results appear in order, none lost or duplicated, and outputs stay stable while stalled.
- Assert rst_n low while both stages are valid -> out_valid drops immediately (asynchronous); out_result = 0; no stale beat appears after release.
